// File: rtl/aes_uart_sequencer.sv
// Sequencer between the UART receive/transmit buffers and the AES core.
// Optional macro AES_TIMEOUT_EN aborts a block stuck in AES_WAIT and sets a sticky error.
module aes_uart_sequencer #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_empty,
   input  logic [127:0]     rx_data,
   output logic             rx_read_en,
   input  logic             rekey,
   output logic [127:0]     aes_key,
   output logic             aes_key_valid,
   output logic [127:0]     aes_din,
   output logic             aes_start,
   input  logic             aes_done,
   input  logic [127:0]     aes_dout,
   input  logic             tx_busy,
   output logic [127:0]     tx_data,
   output logic             tx_write_en,
   output logic             busy,
   output logic [CNT_W-1:0] block_count,
   output logic             error
);

   typedef enum logic [2:0] {
      IDLE, RX_REQ, RX_CAP, AES_START, AES_WAIT, TX_PUSH
   } state_t;

   state_t             state_q, state_d;
   logic               key_pending_q, key_pending_d;
   logic [127:0]       aes_key_q, aes_key_d;
   logic               aes_key_valid_q, aes_key_valid_d;
   logic [127:0]       aes_din_q, aes_din_d;
   logic [127:0]       tx_data_q, tx_data_d;
   logic [CNT_W-1:0]   block_count_q, block_count_d;

`ifdef AES_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic               error_q, error_d;
`endif

   always_comb begin
      state_d         = state_q;
      key_pending_d   = key_pending_q;
      aes_key_d       = aes_key_q;
      aes_key_valid_d = aes_key_valid_q;
      aes_din_d       = aes_din_q;
      tx_data_d       = tx_data_q;
      block_count_d   = block_count_q;
      rx_read_en      = 1'b0;
      aes_start       = 1'b0;
      tx_write_en     = 1'b0;
`ifdef AES_TIMEOUT_EN
      tmo_cnt_d       = tmo_cnt_q;
      error_d         = error_q;
`endif
      unique case (state_q)
         IDLE: if (!rx_empty) state_d = RX_REQ;
         RX_REQ: begin
            rx_read_en = 1'b1;
            state_d    = RX_CAP;
         end
         RX_CAP: begin
            if (key_pending_q) begin
               aes_key_d       = rx_data;
               aes_key_valid_d = 1'b1;
               key_pending_d   = 1'b0;
               state_d         = IDLE;
            end else begin
               aes_din_d = rx_data;
               state_d   = AES_START;
            end
         end
         AES_START: begin
            aes_start = 1'b1;
`ifdef AES_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            state_d   = AES_WAIT;
         end
         AES_WAIT: begin
            if (aes_done) begin
               tx_data_d = aes_dout;
               state_d   = TX_PUSH;
            end
`ifdef AES_TIMEOUT_EN
            // aes_done takes priority over a timeout landing in the same cycle
            else if (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         TX_PUSH: begin
            if (!tx_busy) begin
               tx_write_en   = 1'b1;
               block_count_d = block_count_q + 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A rekey arriving with a key capture keeps the flag set for the next block
      if (rekey) key_pending_d = 1'b1;
      // Strobes are suppressed while reset is asserted so an aborted block emits nothing
      if (reset) begin
         rx_read_en  = 1'b0;
         aes_start   = 1'b0;
         tx_write_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         key_pending_q   <= 1'b1;
         aes_key_q       <= '0;
         aes_key_valid_q <= 1'b0;
         aes_din_q       <= '0;
         tx_data_q       <= '0;
         block_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         key_pending_q   <= key_pending_d;
         aes_key_q       <= aes_key_d;
         aes_key_valid_q <= aes_key_valid_d;
         aes_din_q       <= aes_din_d;
         tx_data_q       <= tx_data_d;
         block_count_q   <= block_count_d;
      end
   end

`ifdef AES_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         error_q   <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         error_q   <= error_d;
      end
   end
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign aes_key       = aes_key_q;
   assign aes_key_valid = aes_key_valid_q;
   assign aes_din       = aes_din_q;
   assign tx_data       = tx_data_q;
   assign block_count   = block_count_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Directed bench for aes_uart_sequencer: key load, data path, backpressure, rekey,
// mid-flight reset, counter wrap (CNT_W=2) and, with AES_TIMEOUT_EN, the timeout abort.
module tb_aes_uart_sequencer;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset, rx_empty, rekey, aes_done, tx_busy;
   logic [127:0]     rx_data, aes_dout;
   logic             rx_read_en, aes_key_valid, aes_start, tx_write_en, busy, error;
   logic [127:0]     aes_key, aes_din, tx_data;
   logic [CNT_W-1:0] block_count;

   int n_tests = 0, n_fail = 0;
   int cnt_rd = 0, cnt_st = 0, cnt_tx = 0;
   logic [127:0] last_tx = '0;

   aes_uart_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data),
      .rx_read_en(rx_read_en), .rekey(rekey), .aes_key(aes_key),
      .aes_key_valid(aes_key_valid), .aes_din(aes_din), .aes_start(aes_start),
      .aes_done(aes_done), .aes_dout(aes_dout), .tx_busy(tx_busy), .tx_data(tx_data),
      .tx_write_en(tx_write_en), .busy(busy), .block_count(block_count), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_read_en)  cnt_rd <= cnt_rd + 1;
      if (aes_start)   cnt_st <= cnt_st + 1;
      if (tx_write_en) begin
         cnt_tx  <= cnt_tx + 1;
         last_tx <= tx_data;
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_block(input logic [127:0] d);
      int n = 0;
      rx_data  = d;
      rx_empty = 1'b0;
      @(negedge clk);
      while (!rx_read_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rd_seen", 128'(n < 50), 128'd1);
      rx_empty = 1'b1;
   endtask

   task automatic load_key(input logic [127:0] k);
      send_block(k);
      repeat (2) @(negedge clk);
      chk("key", aes_key, k);
      chk("key_valid", 128'(aes_key_valid), 128'd1);
      chk("key_idle", 128'(busy), 128'd0);
   endtask

   task automatic wait_start(input logic [127:0] p);
      int n = 0;
      while (!aes_start && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("start_seen", 128'(n < 50), 128'd1);
      chk("aes_din", aes_din, p);
   endtask

   task automatic run_data(input logic [127:0] p, input logic [127:0] c,
                           input int lat, input int bsy, input bit rk);
      int w0, s0, r0;
      logic [CNT_W-1:0] bc0;
      w0  = cnt_tx;
      s0  = cnt_st;
      bc0 = block_count;
      send_block(p);
      wait_start(p);
      @(negedge clk);
      if (rk) begin
         rekey = 1'b1;
         @(negedge clk);
         rekey = 1'b0;
      end
      repeat (lat) @(negedge clk);
      tx_busy  = (bsy > 0);
      rx_empty = ~(bsy > 0);
      aes_done = 1'b1;
      aes_dout = c;
      @(negedge clk);
      aes_done = 1'b0;
      aes_dout = '0;
      if (bsy > 0) begin
         r0 = cnt_rd;
         repeat (bsy) begin
            chk("bp_no_push", 128'(tx_write_en), 128'd0);
            @(negedge clk);
         end
         chk("bp_busy", 128'(busy), 128'd1);
         chk("bp_no_pop", 128'(cnt_rd), 128'(r0));
         chk("bp_tx_cnt", 128'(cnt_tx), 128'(w0));
         tx_busy  = 1'b0;
         rx_empty = 1'b1;
      end
      @(negedge clk);
      chk("push_once", 128'(cnt_tx), 128'(w0 + 1));
      chk("start_once", 128'(cnt_st), 128'(s0 + 1));
      chk("tx_data", last_tx, c);
      chk("blk_cnt", 128'(block_count), 128'(CNT_W'(bc0 + 1'b1)));
   endtask

   initial begin
      logic [CNT_W-1:0] wrap_exp [5];
      int w0;
      wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      reset = 1'b1; rx_empty = 1'b1; rekey = 1'b0; aes_done = 1'b0; tx_busy = 1'b0;
      rx_data = '0; aes_dout = '0;
      repeat (3) @(negedge clk);
      chk("rst_key", aes_key, 128'd0);
      chk("rst_kv", 128'(aes_key_valid), 128'd0);
      chk("rst_din", aes_din, 128'd0);
      chk("rst_tx", tx_data, 128'd0);
      chk("rst_cnt", 128'(block_count), 128'd0);
      chk("rst_err", 128'(error), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      reset = 1'b0;
      @(negedge clk);

      // key then data
      load_key(128'h000102030405060708090a0b0c0d0e0f);
      run_data(128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 0, 1'b0);
      // transmitter backpressure
      run_data(128'h11111111111111111111111111111111,
               128'hc1c1c1c1c1c1c1c1c1c1c1c1c1c1c1c1, 3, 20, 1'b0);
      // rekey mid-flight: old block completes, next block is a key
      run_data(128'h22222222222222222222222222222222,
               128'hc2c2c2c2c2c2c2c2c2c2c2c2c2c2c2c2, 4, 0, 1'b1);
      load_key(128'hfeedfacefeedfacefeedfacefeedface);
      run_data(128'h33333333333333333333333333333333,
               128'hc3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3, 2, 0, 1'b0);

      // reset mid-operation
      w0 = cnt_tx;
      send_block(128'h44444444444444444444444444444444);
      wait_start(128'h44444444444444444444444444444444);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_key", aes_key, 128'd0);
      chk("mid_kv", 128'(aes_key_valid), 128'd0);
      chk("mid_din", aes_din, 128'd0);
      chk("mid_cnt", 128'(block_count), 128'd0);
      chk("mid_busy", 128'(busy), 128'd0);
      aes_done = 1'b1;
      aes_dout = 128'hdead;
      repeat (3) @(negedge clk);
      aes_done = 1'b0;
      chk("mid_no_push", 128'(cnt_tx), 128'(w0));
      load_key(128'habcdabcdabcdabcdabcdabcdabcdabcd);

      // counter wrap with CNT_W=2
      for (int i = 0; i < 5; i++) begin
         run_data(128'(i + 100), 128'(i + 200), 1, 0, 1'b0);
         chk("wrap_seq", 128'(block_count), 128'(wrap_exp[i]));
      end

`ifdef AES_TIMEOUT_EN
      w0 = cnt_tx;
      send_block(128'h55555555555555555555555555555555);
      wait_start(128'h55555555555555555555555555555555);
      repeat (8) @(negedge clk);
      chk("tmo_early", 128'(error), 128'd0);
      @(negedge clk);
      chk("tmo_err", 128'(error), 128'd1);
      chk("tmo_idle", 128'(busy), 128'd0);
      chk("tmo_no_push", 128'(cnt_tx), 128'(w0));
      chk("tmo_cnt", 128'(block_count), 128'd1);
      run_data(128'h66666666666666666666666666666666,
               128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6, 2, 0, 1'b0);
      chk("tmo_sticky", 128'(error), 128'd1);
`else
      chk("err_tied", 128'(error), 128'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
